// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit positions, receive FSM
// states and the bit-timing helper used by both the receiver and transmitter.
package uart_pkg;

    localparam logic [31:0] RXDATA_OFF = 32'h0;
    localparam logic [31:0] STATUS_OFF = 32'h4;

    localparam int STAT_NEMPTY    = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAMING   = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_IE        = 9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int bit_ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver on the picorv32 native bus with a receive FIFO.
// Optional interrupt output and STATUS interrupt-enable bit under UART_RX_IRQ_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
`ifdef UART_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int BIT_TICKS = bit_ticks(CLK_HZ, BAUD);
    localparam int CNT_W     = $clog2(BIT_TICKS);
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_TICKS - 1);

    logic            rx_sync1;
    logic            rx_s;
    logic            rx_prev;
    logic            fall;

    rx_state_t       state_q;
    rx_state_t       state_d;
    logic [CNT_W-1:0] tick_q;
    logic            tick_zero;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;

    logic            load_half;
    logic            load_bit;
    logic            clr_idx;
    logic            shift_en;
    logic            push_req;
    logic            frame_err;

    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_pop;

    logic            ready_q;
    logic            ack;
    logic            is_read;
    logic            sel_rx;
    logic            sel_status;
    logic            wr_status;
    logic            overrun_q;
    logic            framing_q;
    logic            overrun_set;
    logic            ie_q;
    logic [31:0]     status_word;
    logic [31:0]     rdata_c;
    logic            unused_ok;

    assign unused_ok = ^{mem_instr, mem_wdata, mem_addr, mem_wstrb};

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_sync1 <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= serialIn;
            rx_s     <= rx_sync1;
            rx_prev  <= rx_s;
        end
    end

    assign fall      = rx_prev && !rx_s;
    assign tick_zero = (tick_q == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall) state_d = START;
            START: if (tick_zero) state_d = rx_s ? IDLE : DATA;
            DATA:  if (tick_zero && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (tick_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_bit  = 1'b0;
        clr_idx   = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: load_half = fall;
            START: begin
                load_bit = tick_zero && !rx_s;
                clr_idx  = tick_zero && !rx_s;
            end
            DATA: begin
                load_bit = tick_zero;
                shift_en = tick_zero;
            end
            STOP: begin
                push_req  = tick_zero && rx_s;
                frame_err = tick_zero && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            if (load_half) begin
                tick_q <= HALF_LOAD;
            end else if (load_bit) begin
                tick_q <= FULL_LOAD;
            end else if (!tick_zero) begin
                tick_q <= tick_q - 1'b1;
            end
            if (clr_idx) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
        end
    end

    rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .wdata  (shift_q),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Bus: ready_q pulses one cycle per request; the ack cycle carries the
    // read data and performs the pop or the flag clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= enable && mem_valid && !ready_q;
        end
    end

    assign ack         = ready_q && enable;
    assign is_read     = (mem_wstrb == 4'b0000);
    assign sel_rx      = (mem_addr[2] == RXDATA_OFF[2]);
    assign sel_status  = (mem_addr[2] == STATUS_OFF[2]);
    assign fifo_pop    = ack && is_read && sel_rx && !fifo_empty;
    assign wr_status   = ack && !is_read && sel_status && mem_wstrb[0];
    assign overrun_set = push_req && fifo_full && !fifo_pop;

    // Setting wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (wr_status && mem_wdata[STAT_OVERRUN]) begin
                overrun_q <= 1'b0;
            end
            if (frame_err) begin
                framing_q <= 1'b1;
            end else if (wr_status && mem_wdata[STAT_FRAMING]) begin
                framing_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_IRQ_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (ack && !is_read && sel_status && mem_wstrb[1]) begin
                ie_q <= mem_wdata[STAT_IE];
            end
            irq <= ie_q && (!fifo_empty || overrun_q || framing_q);
        end
    end
`else
    assign ie_q = 1'b0;
`endif

    always_comb begin
        status_word                             = '0;
        status_word[STAT_COUNT_LSB +: FCW]      = fifo_count;
        status_word[STAT_IE]                    = ie_q;
        status_word[STAT_FRAMING]               = framing_q;
        status_word[STAT_OVERRUN]               = overrun_q;
        status_word[STAT_FULL]                  = fifo_full;
        status_word[STAT_NEMPTY]                = !fifo_empty;
    end

    always_comb begin
        rdata_c = '0;
        if (sel_status) begin
            rdata_c = status_word;
        end else if (!fifo_empty) begin
            rdata_c = {24'h0, fifo_rdata};
        end
    end

    assign mem_ready = ack ? 1'b1 : 1'bz;
    assign mem_rdata = ack ? rdata_c : 32'bz;

endmodule
